// File: rtl/clock_alarm_multi_pkg.sv
// Shared definitions for the multi-channel alarm: time-vector layout,
// channel state encoding and sizing helpers.
// Contents: TIME_W and field offsets, alarm_state_t, cnt_width(), pack_time().
package clock_alarm_pkg;

  // Time vector layout: {pm, hours_msd, hours_lsd, minutes_msd, minutes_lsd}
  localparam int TIME_W      = 17;
  localparam int MIN_LSD_LSB = 0;
  localparam int MIN_MSD_LSB = 4;
  localparam int HR_LSD_LSB  = 8;
  localparam int HR_MSD_LSB  = 12;
  localparam int PM_BIT      = 16;
  localparam int SECS_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  // Width of a down-counter holding the longer of the two durations in seconds.
  function automatic int cnt_width(input int ring_min, input int snooze_min);
    int max_min;
    max_min = (ring_min > snooze_min) ? ring_min : snooze_min;
    return $clog2(max_min * 60 + 1);
  endfunction

  // Assemble a time vector from its BCD fields.
  function automatic logic [TIME_W-1:0] pack_time(input logic       pm,
                                                  input logic [3:0] h_msd,
                                                  input logic [3:0] h_lsd,
                                                  input logic [3:0] m_msd,
                                                  input logic [3:0] m_lsd);
    logic [TIME_W-1:0] t;
    t                      = '0;
    t[PM_BIT]              = pm;
    t[HR_MSD_LSB  +: 4]    = h_msd;
    t[HR_LSD_LSB  +: 4]    = h_lsd;
    t[MIN_MSD_LSB +: 4]    = m_msd;
    t[MIN_LSD_LSB +: 4]    = m_lsd;
    return t;
  endfunction

endpackage

// File: rtl/clock_alarm_multi_if.sv
// Alarm bus: time/control inputs towards the alarm block and its status outputs.
// master drives time, alarm settings and pulses; slave (the alarm) drives
// ringing, snoozed, display_en and beep.
interface clock_alarm_multi_if import clock_alarm_pkg::*; #(
  parameter int NUM_ALARMS = 2
) ();

  logic                         tick_1hz;
  logic                         en;
  logic [NUM_ALARMS-1:0]        ch_en;
  logic [TIME_W-1:0]            clock_time;
  logic [SECS_W-1:0]            clock_seconds;
  logic [TIME_W*NUM_ALARMS-1:0] alarm_time;
  logic                         alarm_reset;
  logic                         snooze;
  logic [NUM_ALARMS-1:0]        ringing;
  logic [NUM_ALARMS-1:0]        snoozed;
  logic                         display_en;
  logic                         beep;

  modport master (
    output tick_1hz, en, ch_en, clock_time, clock_seconds, alarm_time,
           alarm_reset, snooze,
    input  ringing, snoozed, display_en, beep
  );

  modport slave (
    input  tick_1hz, en, ch_en, clock_time, clock_seconds, alarm_time,
           alarm_reset, snooze,
    output ringing, snoozed, display_en, beep
  );

endinterface

// File: rtl/clock_alarm_multi_channel.sv
// One alarm channel: time compare, IDLE/RING/SNOOZE FSM and seconds down-counter.
// Latency: ringing/snoozed change on the clock edge that samples the event.
// Backpressure: none; tick, snooze and dismiss are single-cycle strobes.
// Ports: clk_fast, reset_n, tick_1hz, en, ch_en, clock_time, clock_seconds,
//        alarm_time, alarm_reset, snooze -> ringing, snoozed, ring_next.
module alarm_channel import clock_alarm_pkg::*; #(
  parameter int RING_MIN   = 5,
  parameter int SNOOZE_MIN = 9
) (
  input  logic              clk_fast,
  input  logic              reset_n,
  input  logic              tick_1hz,
  input  logic              en,
  input  logic              ch_en,
  input  logic [TIME_W-1:0] clock_time,
  input  logic [SECS_W-1:0] clock_seconds,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              alarm_reset,
  input  logic              snooze,
  output logic              ringing,
  output logic              snoozed,
  output logic              ring_next
);

  localparam int               CNT_W       = cnt_width(RING_MIN, SNOOZE_MIN);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_MIN * 60);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * 60);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  alarm_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             trigger;

  // Seconds == 00 on a tick makes this fire once per matching minute.
  assign trigger = tick_1hz && en && ch_en &&
                   (clock_time == alarm_time) && (clock_seconds == 8'h00);

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: disable > dismiss > snooze > tick-driven expiry/trigger.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en || !ch_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (alarm_reset) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (snooze && (state == RING)) begin
      // Loads the full snooze time even if a tick lands in this cycle.
      state_nxt = SNOOZE;
      cnt_nxt   = SNOOZE_LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt = RING;
            cnt_nxt   = RING_LOAD;
          end
        end
        RING: begin
          // A fresh trigger while ringing is ignored (no reload).
          if (tick_1hz) begin
            if (cnt == CNT_ONE) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CNT_ONE;
            end
          end
        end
        SNOOZE: begin
          if (tick_1hz) begin
            if (cnt == CNT_ONE) begin
              state_nxt = RING;
              cnt_nxt   = RING_LOAD;
            end else begin
              cnt_nxt = cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign ringing   = (state == RING);
  assign snoozed   = (state == SNOOZE);
  // Lets the top register its outputs on the same edge as the channel state.
  assign ring_next = (state_nxt == RING);

endmodule

// File: rtl/clock_alarm_multi.sv
// Multi-channel alarm: NUM_ALARMS channels plus shared blink phase and beep tone.
// Latency: all outputs registered, updating on the edge that samples the event.
// Backpressure: none; driven by a 1-cycle 1 Hz tick and single-cycle pulses.
// Ports: clk_fast, reset_n (async, active low), io (slave side of the alarm bus).
module clock_alarm_multi import clock_alarm_pkg::*; #(
  parameter int NUM_ALARMS = 2,
  parameter int RING_MIN   = 5,
  parameter int SNOOZE_MIN = 9,
  parameter int BEEP_DIV   = 1024
) (
  input  logic                clk_fast,
  input  logic                reset_n,
  clock_alarm_multi_if.slave  io
);

  localparam int               DIV_W    = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_DIV - 1);

  logic [NUM_ALARMS-1:0] ring_q;
  logic [NUM_ALARMS-1:0] snz_q;
  logic [NUM_ALARMS-1:0] ring_nxt;
  logic                  any_ring_nxt;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
    alarm_channel #(
      .RING_MIN   (RING_MIN),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk_fast      (clk_fast),
      .reset_n       (reset_n),
      .tick_1hz      (io.tick_1hz),
      .en            (io.en),
      .ch_en         (io.ch_en[gi]),
      .clock_time    (io.clock_time),
      .clock_seconds (io.clock_seconds),
      .alarm_time    (io.alarm_time[gi*TIME_W +: TIME_W]),
      .alarm_reset   (io.alarm_reset),
      .snooze        (io.snooze),
      .ringing       (ring_q[gi]),
      .snoozed       (snz_q[gi]),
      .ring_next     (ring_nxt[gi])
    );
  end

  assign io.ringing = ring_q;
  assign io.snoozed = snz_q;
  assign any_ring_nxt = |ring_nxt;

  logic             blink_phase, phase_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             tone, tone_nxt;
  logic             display_en_q, beep_q;

  // Everything below is computed from the channels' next state so that
  // display_en and beep always agree with the ringing flags of the same cycle
  // (e.g. en=0 blanks the beep on the very edge ringing drops).
  always_comb begin
    phase_nxt = blink_phase;
    div_nxt   = div_cnt;
    tone_nxt  = tone;
    if (!any_ring_nxt) begin
      // Phase held at 0 while silent, so the trigger tick flips it to 1.
      phase_nxt = 1'b0;
      div_nxt   = '0;
      tone_nxt  = 1'b0;
    end else begin
      if (io.tick_1hz) begin
        phase_nxt = ~blink_phase;
      end
      if (div_cnt == DIV_LAST) begin
        div_nxt  = '0;
        tone_nxt = ~tone;
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      blink_phase  <= 1'b0;
      div_cnt      <= '0;
      tone         <= 1'b0;
      display_en_q <= 1'b1;
      beep_q       <= 1'b0;
    end else begin
      blink_phase  <= phase_nxt;
      div_cnt      <= div_nxt;
      tone         <= tone_nxt;
      display_en_q <= ~(any_ring_nxt && phase_nxt);
      beep_q       <= tone_nxt && phase_nxt && any_ring_nxt;
    end
  end

  assign io.display_en = display_en_q;
  assign io.beep       = beep_q;

endmodule

// File: tb/tb_clock_alarm_multi.sv
// Bench for clock_alarm_multi: directed sequences, a vector table and random
// stimulus, all checked against a seconds/cycles-count reference model.
module tb_clock_alarm_multi;
  import clock_alarm_pkg::*;

  localparam int NA       = 2;
  localparam int RM       = 1;
  localparam int SM       = 1;
  localparam int BD       = 4;
  localparam int TICK_PER = 10;

  logic clk_fast = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_fast = ~clk_fast;

  clock_alarm_multi_if #(.NUM_ALARMS(NA)) bus ();

  clock_alarm_multi #(
    .NUM_ALARMS (NA),
    .RING_MIN   (RM),
    .SNOOZE_MIN (SM),
    .BEEP_DIV   (BD)
  ) dut (
    .clk_fast (clk_fast),
    .reset_n  (reset_n),
    .io       (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: per-channel mode (0 idle, 1 ringing, 2 snoozed) with
  // seconds left, plus how long (cycles / ticks) something has been ringing.
  int m_mode [NA];
  int m_left [NA];
  int m_ring_cycles;
  int m_ring_ticks;

  task automatic model_step();
    logic any;
    logic trig;
    any = 1'b0;
    for (int i = 0; i < NA; i++) begin
      trig = bus.tick_1hz && bus.en && bus.ch_en[i] &&
             (bus.clock_time == bus.alarm_time[i*TIME_W +: TIME_W]) &&
             (bus.clock_seconds == 8'h00);
      if (!bus.en || !bus.ch_en[i]) m_mode[i] = 0;
      else if (bus.alarm_reset) m_mode[i] = 0;
      else if (bus.snooze && m_mode[i] == 1) begin
        m_mode[i] = 2;
        m_left[i] = SM * 60;
      end else if (m_mode[i] == 0) begin
        if (trig) begin
          m_mode[i] = 1;
          m_left[i] = RM * 60;
        end
      end else if (bus.tick_1hz) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          if (m_mode[i] == 1) m_mode[i] = 0;
          else begin
            m_mode[i] = 1;
            m_left[i] = RM * 60;
          end
        end
      end
      if (m_mode[i] == 1) any = 1'b1;
    end
    if (any) begin
      m_ring_cycles = m_ring_cycles + 1;
      if (bus.tick_1hz) m_ring_ticks = m_ring_ticks + 1;
    end else begin
      m_ring_cycles = 0;
      m_ring_ticks  = 0;
    end
  endtask

  always @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NA; i++) begin
        m_mode[i] = 0;
        m_left[i] = 0;
      end
      m_ring_cycles = 0;
      m_ring_ticks  = 0;
    end else begin
      model_step();
    end
  end

  function automatic logic [2*NA+1:0] model_out();
    logic [NA-1:0] r, s;
    logic any, phase, tone;
    for (int i = 0; i < NA; i++) begin
      r[i] = (m_mode[i] == 1);
      s[i] = (m_mode[i] == 2);
    end
    any   = |r;
    phase = ((m_ring_ticks % 2) == 1);
    tone  = (((m_ring_cycles / BD) % 2) == 1);
    return {r, s, !(any && phase), tone && phase && any};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs set, edge, then sample on the falling edge.
  task automatic cyc(input logic t);
    bus.tick_1hz = t;
    @(posedge clk_fast);
    @(negedge clk_fast);
    bus.tick_1hz    = 1'b0;
    bus.alarm_reset = 1'b0;
    bus.snooze      = 1'b0;
    chk("model", 32'({bus.ringing, bus.snoozed, bus.display_en, bus.beep}),
        32'(model_out()));
  endtask

  task automatic sec();
    cyc(1'b1);
    repeat (TICK_PER - 1) cyc(1'b0);
  endtask

  typedef struct {
    logic          en;
    logic [NA-1:0] ch_en;
    logic [7:0]    secs;
    logic          tick;
    logic          arst;
    logic          snz;
    logic [NA-1:0] exp_ring;
    logic [NA-1:0] exp_snz;
  } vec_t;

  vec_t tbl [13];

  logic [TIME_W-1:0] t0730, t1200p, t1111p, t0729;
  logic [9:0]        pat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 1 ms");
    $fatal(1);
  end

  initial begin
    t0730  = pack_time(1'b0, 4'h0, 4'h7, 4'h3, 4'h0);
    t0729  = pack_time(1'b0, 4'h0, 4'h7, 4'h2, 4'h9);
    t1200p = pack_time(1'b1, 4'h1, 4'h2, 4'h0, 4'h0);
    t1111p = pack_time(1'b1, 4'h1, 4'h1, 4'h1, 4'h1);

    tbl[0]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00};
    tbl[1]  = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00};
    tbl[2]  = '{1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    tbl[3]  = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00};
    tbl[4]  = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 2'b11, 8'h01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[6]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00};
    tbl[7]  = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11};
    tbl[8]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11};
    tbl[9]  = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00};
    tbl[12] = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    bus.tick_1hz      = 1'b0;
    bus.en            = 1'b0;
    bus.ch_en         = '0;
    bus.clock_time    = '0;
    bus.clock_seconds = 8'h00;
    bus.alarm_time    = '0;
    bus.alarm_reset   = 1'b0;
    bus.snooze        = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_fast);
    chk("rst_ring", 32'(bus.ringing), 32'(0));
    chk("rst_snz",  32'(bus.snoozed), 32'(0));
    chk("rst_disp", 32'(bus.display_en), 32'(1));
    chk("rst_beep", 32'(bus.beep), 32'(0));
    reset_n = 1'b1;

    // Trigger, blink/beep pattern and 60-tick auto-stop
    bus.en            = 1'b1;
    bus.ch_en         = 2'b01;
    bus.alarm_time    = {t1111p, t0730};
    bus.clock_time    = t0729;
    bus.clock_seconds = 8'h59;
    sec();
    chk("s1_no_match", 32'(bus.ringing), 32'(0));
    bus.clock_time    = t0730;
    bus.clock_seconds = 8'h00;
    cyc(1'b1);
    chk("s1_trigger", 32'(bus.ringing), 32'(2'b01));
    chk("s2_disp_first", 32'(bus.display_en), 32'(0));
    bus.clock_seconds = 8'h01;
    pat = {9'b0, bus.beep};
    for (int c = 0; c < TICK_PER - 1; c++) begin
      cyc(1'b0);
      pat = {pat[8:0], bus.beep};
    end
    chk("s2_beep_lit_sec", 32'(pat), 32'(10'b0001111000));
    cyc(1'b1);
    chk("s2_disp_second", 32'(bus.display_en), 32'(1));
    pat = {9'b0, bus.beep};
    for (int c = 0; c < TICK_PER - 1; c++) begin
      cyc(1'b0);
      pat = {pat[8:0], bus.beep};
    end
    chk("s2_beep_dark_sec", 32'(pat), 32'(0));
    for (int k = 2; k < 60; k++) begin
      cyc(1'b1);
      chk("s2_blink", 32'(bus.display_en), 32'(k % 2));
      repeat (TICK_PER - 1) cyc(1'b0);
    end
    chk("s1_ring_tick59", 32'(bus.ringing), 32'(2'b01));
    cyc(1'b1);
    chk("s1_stop_tick60", 32'(bus.ringing), 32'(0));
    chk("s1_disp_after", 32'(bus.display_en), 32'(1));
    repeat (TICK_PER - 1) cyc(1'b0);

    // Snooze at tick 20 (same cycle as the tick), re-ring, full ring
    bus.clock_seconds = 8'h00;
    cyc(1'b1);
    chk("s3_trigger", 32'(bus.ringing), 32'(2'b01));
    bus.clock_seconds = 8'h01;
    repeat (TICK_PER - 1) cyc(1'b0);
    for (int k = 1; k < 20; k++) sec();
    bus.snooze = 1'b1;
    cyc(1'b1);
    chk("s3_snoozed", 32'(bus.snoozed), 32'(2'b01));
    chk("s3_ring_off", 32'(bus.ringing), 32'(0));
    repeat (TICK_PER - 1) cyc(1'b0);
    for (int k = 1; k < 60; k++) sec();
    chk("s3_snz_tick59", 32'(bus.snoozed), 32'(2'b01));
    cyc(1'b1);
    chk("s3_rering", 32'(bus.ringing), 32'(2'b01));
    chk("s3_snz_clr", 32'(bus.snoozed), 32'(0));
    repeat (TICK_PER - 1) cyc(1'b0);
    for (int k = 1; k < 60; k++) sec();
    chk("s3_ring_tick59", 32'(bus.ringing), 32'(2'b01));
    cyc(1'b1);
    chk("s3_stop", 32'(bus.ringing), 32'(0));
    repeat (TICK_PER - 1) cyc(1'b0);

    // Dismiss beats snooze; re-trigger needs seconds 00
    bus.clock_seconds = 8'h00;
    cyc(1'b1);
    chk("s4_trigger", 32'(bus.ringing), 32'(2'b01));
    bus.clock_seconds = 8'h01;
    repeat (29) cyc(1'b0);
    bus.alarm_reset = 1'b1;
    bus.snooze      = 1'b1;
    cyc(1'b0);
    chk("s4_dismiss_ring", 32'(bus.ringing), 32'(0));
    chk("s4_dismiss_snz", 32'(bus.snoozed), 32'(0));
    sec();
    chk("s4_no_retrig_01", 32'(bus.ringing), 32'(0));
    bus.clock_seconds = 8'h00;
    cyc(1'b1);
    chk("s4_retrigger", 32'(bus.ringing), 32'(2'b01));
    bus.alarm_reset = 1'b1;
    cyc(1'b0);

    // Multi-channel / enable table
    bus.alarm_time = {t1200p, t1200p};
    bus.clock_time = t1200p;
    for (int v = 0; v < 13; v++) begin
      bus.en            = tbl[v].en;
      bus.ch_en         = tbl[v].ch_en;
      bus.clock_seconds = tbl[v].secs;
      bus.alarm_reset   = tbl[v].arst;
      bus.snooze        = tbl[v].snz;
      cyc(tbl[v].tick);
      chk($sformatf("tbl%0d_ring", v), 32'(bus.ringing), 32'(tbl[v].exp_ring));
      chk($sformatf("tbl%0d_snz", v),  32'(bus.snoozed), 32'(tbl[v].exp_snz));
      if (!tbl[v].en) begin
        chk($sformatf("tbl%0d_disp", v), 32'(bus.display_en), 32'(1));
        chk($sformatf("tbl%0d_beep", v), 32'(bus.beep), 32'(0));
      end
    end

    // Async reset mid-ring, then a non-00 second must not trigger
    bus.en            = 1'b1;
    bus.ch_en         = 2'b01;
    bus.alarm_time    = {t1111p, t0730};
    bus.clock_time    = t0730;
    bus.clock_seconds = 8'h00;
    cyc(1'b1);
    chk("s6_ring", 32'(bus.ringing), 32'(2'b01));
    bus.clock_seconds = 8'h01;
    repeat (4) cyc(1'b0);
    chk("s6_beep_pre", 32'(bus.beep), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_rst_ring", 32'(bus.ringing), 32'(0));
    chk("s6_rst_snz",  32'(bus.snoozed), 32'(0));
    chk("s6_rst_disp", 32'(bus.display_en), 32'(1));
    chk("s6_rst_beep", 32'(bus.beep), 32'(0));
    @(negedge clk_fast);
    reset_n = 1'b1;
    bus.clock_seconds = 8'h05;
    cyc(1'b1);
    chk("s6_no_trig_05", 32'(bus.ringing), 32'(0));
    repeat (TICK_PER - 1) cyc(1'b0);

    // Random stimulus against the model
    bus.alarm_time = {t1200p, t0730};
    bus.ch_en      = 2'b11;
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 3))
        0, 1:    bus.clock_time = t0730;
        2:       bus.clock_time = t1200p;
        default: bus.clock_time = t1111p;
      endcase
      bus.clock_seconds = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'h00;
      bus.en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 29) == 0) bus.ch_en = NA'($urandom_range(0, 3));
      for (int c = 0; c < TICK_PER; c++) begin
        bus.snooze      = ($urandom_range(0, 99) < 2);
        bus.alarm_reset = ($urandom_range(0, 199) == 0);
        cyc(c == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
